// File: rtl/apb_rr_arbiter.sv
// Two-requester APB arbiter: round-robin grant per transfer, registered
// SETUP/ACCESS replay on a single downstream APB port, response routed
// back to the owning requester only.
module apb_rr_arbiter #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*APB_ADDR_WIDTH-1:0] up_paddr,
    input  logic [2*APB_DATA_WIDTH-1:0] up_pwdata,
    input  logic [1:0]                  up_pwrite,
    input  logic [1:0]                  up_psel,
    input  logic [1:0]                  up_penable,
    output logic [2*APB_DATA_WIDTH-1:0] up_prdata,
    output logic [1:0]                  up_pready,
    output logic [1:0]                  up_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]   dn_paddr,
    output logic [APB_DATA_WIDTH-1:0]   dn_pwdata,
    output logic                        dn_pwrite,
    output logic                        dn_psel,
    output logic                        dn_penable,
    input  logic [APB_DATA_WIDTH-1:0]   dn_prdata,
    input  logic                        dn_pready,
    input  logic                        dn_pslverr,
    output logic [1:0]                  gnt
);

    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic [1:0]      r_gnt;
    logic [AW-1:0]   r_paddr;
    logic [DW-1:0]   r_pwdata;
    logic            r_pwrite;

    logic            w_req;
    logic            w_win;
    logic            w_done;
    logic [AW-1:0]   w_paddr;
    logic [DW-1:0]   w_pwdata;
    logic            w_pwrite;

    assign w_req = |up_psel;

    // Round-robin winner: a lone requester wins, on contention the one not granted last
    always_comb begin
        w_win = 1'b0;
        case (up_psel)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
        w_paddr  = w_win ? up_paddr[2*AW-1:AW]   : up_paddr[AW-1:0];
        w_pwdata = w_win ? up_pwdata[2*DW-1:DW]  : up_pwdata[DW-1:0];
        w_pwrite = w_win ? up_pwrite[1]          : up_pwrite[0];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; requests are only sampled in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (dn_pready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: downstream phase strobes and same-cycle response to the owner
    always_comb begin
        dn_psel    = 1'b0;
        dn_penable = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_SETUP: begin
                dn_psel = 1'b1;
            end
            S_ACCESS: begin
                dn_psel    = 1'b1;
                dn_penable = 1'b1;
                w_done     = dn_pready;
            end
            default: ;
        endcase
        up_pready  = r_gnt & {2{w_done}};
        up_pslverr = r_gnt & {2{w_done & dn_pslverr}};
    end

    // Capture the winning transfer and owner; address/data hold their value in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_gnt    <= 2'b00;
            r_last   <= 1'b1;
        end else if (r_state == S_IDLE && w_req) begin
            r_paddr  <= w_paddr;
            r_pwdata <= w_pwdata;
            r_pwrite <= w_pwrite;
            r_gnt    <= w_win ? 2'b10 : 2'b01;
            r_last   <= w_win;
        end else if (w_done) begin
            r_gnt    <= 2'b00;
        end
    end

    assign dn_paddr  = r_paddr;
    assign dn_pwdata = r_pwdata;
    assign dn_pwrite = r_pwrite;
    assign gnt       = r_gnt;
    assign up_prdata = {2{dn_prdata}};

    // Upstream enable is informational only: it must never be raised without select
    a_penable_has_psel: assert property (@(posedge clk) disable iff (!rst_n)
        ((up_penable & ~up_psel) == 2'b00));

endmodule
